// File: rtl/event_sync_arb.sv
// Multi-channel async event capture: synchronise, edge-detect, latch pending, round-robin valid/ack.
// Define EVSYNC_AUTO_ACK_EN to ignore ack and emit one-cycle valid pulses per event.
module event_sync_arb #(
  parameter int CH          = 4,
  parameter int ID_W        = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [CH-1:0]   sig,
  input  logic            ack,
  input  logic            clr_ovf,
  output logic            valid,
  output logic [ID_W-1:0] id,
  output logic [CH-1:0]   pending,
  output logic [CH-1:0]   overflow
);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t          state_q, state_d;
  logic [CH-1:0]   sync_q [SYNC_STAGES];
  logic [CH-1:0]   prev_q;
  logic [CH-1:0]   edge_det;
  logic [CH-1:0]   gnt_vec;
  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] gnt_id;
  logic            gnt_found;
  logic            do_grant;
  logic            ack_eff;

`ifdef EVSYNC_AUTO_ACK_EN
  assign ack_eff = ack | 1'b1;
`else
  assign ack_eff = ack;
`endif

  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int step);
    return ID_W'((int'(base) + step) % CH);
  endfunction

  // Input synchroniser chain plus previous-sample stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= sig;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_det = sync_q[SYNC_STAGES-1] & ~prev_q;

  // First pending channel strictly after the last-granted one, wrapping
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int k = 1; k <= CH; k++) begin
      if (!gnt_found && pending[rr_index(ptr_q, k)]) begin
        gnt_found = 1'b1;
        gnt_id    = rr_index(ptr_q, k);
      end
    end
  end

  assign do_grant = gnt_found && ((state_q == S_IDLE) || ack_eff);
  assign gnt_vec  = do_grant ? (CH'(1) << gnt_id) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (gnt_found) state_d = S_HOLD;
      S_HOLD:  if (ack_eff && !gnt_found) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    valid = (state_q == S_HOLD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id    <= '0;
      ptr_q <= ID_W'(CH - 1);
    end else if (do_grant) begin
      id    <= gnt_id;
      ptr_q <= gnt_id;
    end
  end

  // A fresh edge on the channel being granted re-arms it without counting as lost
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending  <= '0;
      overflow <= '0;
    end else begin
      pending  <= edge_det | (pending & ~gnt_vec);
      overflow <= (clr_ovf ? '0 : overflow) | (edge_det & pending & ~gnt_vec);
    end
  end

endmodule

// File: tb/tb_event_sync_arb.sv
// Directed bench for event_sync_arb with an event-level reference model checked every cycle.
module tb_event_sync_arb;
  localparam int CH = 4;
  localparam int ID_W = 2;
  localparam int SS = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [CH-1:0]   sig;
  logic            ack;
  logic            clr_ovf;
  logic            valid;
  logic [ID_W-1:0] id;
  logic [CH-1:0]   pending;
  logic [CH-1:0]   overflow;

  int n_checks = 0;
  int n_fail = 0;

  event_sync_arb #(.CH(CH), .ID_W(ID_W), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .sig(sig), .ack(ack), .clr_ovf(clr_ovf),
    .valid(valid), .id(id), .pending(pending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Reference model: sig history delayed by the synchroniser depth, sticky
  // request set, and a round-robin presenter.
  logic [CH-1:0] m_hist [SS+1];
  logic          m_valid;
  int            m_id, m_ptr;
  logic [CH-1:0] m_pend, m_ovf;

  function automatic int rr_pick(input logic [CH-1:0] p, input int ptr);
    for (int k = 1; k <= CH; k++)
      if (p[(ptr + k) % CH]) return (ptr + k) % CH;
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    logic [CH-1:0] ev, gm;
    int            g;
    logic          ack_e;
    if (reset) begin
      for (int s = 0; s <= SS; s++) m_hist[s] = '0;
      m_valid = 1'b0; m_id = 0; m_ptr = CH - 1; m_pend = '0; m_ovf = '0;
    end else begin
`ifdef EVSYNC_AUTO_ACK_EN
      ack_e = 1'b1;
`else
      ack_e = ack;
`endif
      ev = m_hist[SS-1] & ~m_hist[SS];
      g = -1;
      if ((!m_valid || ack_e) && m_pend != '0) g = rr_pick(m_pend, m_ptr);
      gm = (g >= 0) ? (CH'(1) << g) : '0;
      m_ovf  = (clr_ovf ? '0 : m_ovf) | (ev & m_pend & ~gm);
      m_pend = ev | (m_pend & ~gm);
      if (g >= 0) begin
        m_valid = 1'b1; m_id = g; m_ptr = g;
      end else if (m_valid && ack_e) begin
        m_valid = 1'b0;
      end
      for (int s = SS; s > 0; s--) m_hist[s] = m_hist[s-1];
      m_hist[0] = sig;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("model_valid", valid, m_valid);
      chk("model_pending", pending, m_pend);
      chk("model_overflow", overflow, m_ovf);
      if (m_valid) chk("model_id", id, m_id);
    end
  end

  initial begin
    reset = 1'b1; sig = '0; ack = 1'b0; clr_ovf = 1'b0;
    @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_id", id, 0);
    chk("rst_pending", pending, 0);
    chk("rst_overflow", overflow, 0);
    tick(1);
    #2 reset = 1'b0;
    tick(2);

`ifdef EVSYNC_AUTO_ACK_EN
    sig = 4'b0111;
    tick(3);
    chk("auto_pend", pending, 4'b0111);
    tick(1); chk("auto_v0", valid, 1); chk("auto_id0", id, 0);
    tick(1); chk("auto_v1", valid, 1); chk("auto_id1", id, 1);
    tick(1); chk("auto_v2", valid, 1); chk("auto_id2", id, 2);
    tick(1); chk("auto_end", valid, 0);
    sig = '0;
    tick(4);
`else
    // Single event on ch2
    sig = 4'b0100;
    tick(3);
    chk("single_pend", pending, 4'b0100);
    chk("single_notyet", valid, 0);
    tick(1);
    chk("single_valid", valid, 1);
    chk("single_id", id, 2);
    chk("single_cleared", pending, 0);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("hold_valid", valid, 1);
      chk("hold_id", id, 2);
    end
    ack = 1'b1;
    tick(1);
    chk("single_done", valid, 0);
    ack = 1'b0; sig = '0;
    tick(4);

    // Overflow: two ch1 events while ch0 is held
    sig = 4'b0001;
    tick(4);
    chk("ovf_hold_id", id, 0);
    sig = 4'b0011; tick(3);
    sig = 4'b0001; tick(3);
    sig = 4'b0011; tick(3);
    chk("ovf_set", overflow, 4'b0010);
    chk("ovf_pend", pending, 4'b0010);
    ack = 1'b1;
    tick(1);
    chk("ovf_b2b_valid", valid, 1);
    chk("ovf_b2b_id", id, 1);
    tick(1);
    chk("ovf_single_ch1", valid, 0);
    ack = 1'b0;
    clr_ovf = 1'b1; tick(1); clr_ovf = 1'b0;
    chk("ovf_clr", overflow, 0);

    // Asynchronous reset mid-handshake
    sig = 4'b1101;
    tick(4);
    chk("pre_rst_id", id, 2);
    chk("pre_rst_pend", pending, 4'b1000);
    sig = '0;
    #2 reset = 1'b1;
    #1;
    chk("async_valid", valid, 0);
    chk("async_pend", pending, 0);
    chk("async_ovf", overflow, 0);
    @(negedge clk);
    #2 reset = 1'b0;
    tick(3);

    // Simultaneous edges with ack tied high
    ack = 1'b1;
    sig = 4'b1011;
    tick(3);
    chk("sim_pend", pending, 4'b1011);
    tick(1); chk("sim_id_a", id, 0); chk("sim_v_a", valid, 1);
    tick(1); chk("sim_id_b", id, 1);
    tick(1); chk("sim_id_c", id, 3);
    tick(1); chk("sim_end", valid, 0);
    sig = '0; tick(3);
    sig = 4'b1001;
    tick(4); chk("re_id_a", id, 0); chk("re_v_a", valid, 1);
    tick(1); chk("re_id_b", id, 3);
    tick(1); chk("re_end", valid, 0);
    ack = 1'b0; sig = '0;
    tick(3);

    // ch2 edge landing on ch2's grant cycle
    sig = 4'b0001;
    tick(4);
    chk("coin_hold_id", id, 0);
    sig = 4'b0101; tick(3);
    chk("coin_pend1", pending, 4'b0100);
    sig = 4'b0001; tick(3);
    sig = 4'b0101; tick(2);
    ack = 1'b1;
    tick(1);
    chk("coin_id", id, 2);
    chk("coin_pend_kept", pending, 4'b0100);
    chk("coin_no_ovf", overflow, 0);
    tick(1);
    chk("coin_again_v", valid, 1);
    chk("coin_again_id", id, 2);
    tick(1);
    chk("coin_end", valid, 0);
    ack = 1'b0; sig = '0;
    tick(4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
